// File: rtl/imm_gen_arbiter_if.sv
// Purpose: bundles the request, shared imm_gen and result signals of
//   imm_gen_arbiter into one interface.
// Build option: IMMARB_OPCHK_EN adds out_err (advisory illegal-opcode flag).
// Signals:
//   req_valid[1:0], req_inst0/1, req_tag0/1 : requester side (into arbiter)
//   req_ready[1:0]                          : per-requester accept (out of arbiter)
//   gen_inst / gen_imm                      : shared combinational imm_gen
//   out_valid, out_imm, out_id, out_tag     : registered result (out of arbiter)
//   out_ready                               : consumer accept (into arbiter)
//   dbg_state, dbg_rr_ptr                   : EMPTY/FULL state and round-robin pointer
// Modports: slave = arbiter view, master = environment view.
interface imm_gen_arbiter_if #(
  parameter int INST_W = 32,
  parameter int IMM_W  = 64,
  parameter int TAG_W  = 4
);
  logic [1:0]        req_valid;
  logic [INST_W-1:0] req_inst0;
  logic [INST_W-1:0] req_inst1;
  logic [TAG_W-1:0]  req_tag0;
  logic [TAG_W-1:0]  req_tag1;
  logic [1:0]        req_ready;
  logic [INST_W-1:0] gen_inst;
  logic [IMM_W-1:0]  gen_imm;
  logic              out_valid;
  logic              out_ready;
  logic [IMM_W-1:0]  out_imm;
  logic              out_id;
  logic [TAG_W-1:0]  out_tag;
  logic              dbg_state;
  logic              dbg_rr_ptr;
`ifdef IMMARB_OPCHK_EN
  logic              out_err;
`endif

  modport slave (
    input  req_valid, req_inst0, req_inst1, req_tag0, req_tag1, gen_imm, out_ready,
    output req_ready, gen_inst, out_valid, out_imm, out_id, out_tag,
`ifdef IMMARB_OPCHK_EN
    output out_err,
`endif
    output dbg_state, dbg_rr_ptr
  );

  modport master (
    output req_valid, req_inst0, req_inst1, req_tag0, req_tag1, gen_imm, out_ready,
    input  req_ready, gen_inst, out_valid, out_imm, out_id, out_tag,
`ifdef IMMARB_OPCHK_EN
    input  out_err,
`endif
    input  dbg_state, dbg_rr_ptr
  );
endinterface

// File: rtl/imm_gen_arbiter.sv
// Purpose: shares one combinational imm_gen between requester 0 (decode) and
//   requester 1 (branch-target precompute). Round-robin grant when both are
//   valid; the immediate is captured in a 1-entry output register (1-cycle
//   latency, 1 result/cycle).
// Build option: IMMARB_OPCHK_EN adds a registered out_err flag that marks a
//   granted instruction whose opcode is not an immediate-carrying one.
// Ports:
//   clk    : clock, all state on rising edge
//   rst_n  : synchronous active-low reset
//   bus    : imm_gen_arbiter_if.slave (request, imm_gen and result signals)
//
// Handshake: a request i transfers on a rising edge where req_valid[i] and
//   req_ready[i] are both 1; the result transfers where out_valid and
//   out_ready are both 1. req_ready is one-hot or zero and may depend on
//   req_valid. out_* never change while out_valid=1 and out_ready=0.
module imm_gen_arbiter #(
  parameter int INST_W = 32,
  parameter int IMM_W  = 64,
  parameter int TAG_W  = 4
) (
  input logic               clk,
  input logic               rst_n,
  imm_gen_arbiter_if.slave  bus
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e            state_q, state_d;
  logic              rr_ptr_q, rr_ptr_d;
  logic [IMM_W-1:0]  imm_q, imm_d;
  logic              id_q, id_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
`ifdef IMMARB_OPCHK_EN
  logic              err_q, err_d;
`endif

  logic              load_en;
  logic [1:0]        grant;
  logic              xfer;
  logic              xfer_id;
  logic [INST_W-1:0] gen_inst;

`ifdef IMMARB_OPCHK_EN
  function automatic logic opcode_legal(input logic [6:0] op);
    case (op)
      7'b0000011, 7'b0010011, 7'b0011011, 7'b0010111, 7'b0100011,
      7'b0110111, 7'b1100011, 7'b1100111, 7'b1101111, 7'b1110011:
        opcode_legal = 1'b1;
      default: opcode_legal = 1'b0;
    endcase
  endfunction
`endif

  always_comb begin
    load_en  = (state_q == EMPTY) | bus.out_ready;
    grant    = 2'b00;
    // Nothing is accepted during a reset cycle, so gate the grant with rst_n.
    if (rst_n && load_en) begin
      case (bus.req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = rr_ptr_q ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
    xfer    = |grant;
    xfer_id = grant[1];
    // Only a granted instruction reaches imm_gen; otherwise it sees zero.
    gen_inst = grant[1] ? bus.req_inst1 :
               grant[0] ? bus.req_inst0 : '0;

    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    imm_d    = imm_q;
    id_d     = id_q;
    tag_d    = tag_q;
`ifdef IMMARB_OPCHK_EN
    err_d    = err_q;
`endif
    if (xfer) begin
      state_d  = FULL;
      rr_ptr_d = ~xfer_id;
      imm_d    = bus.gen_imm;
      id_d     = xfer_id;
      tag_d    = xfer_id ? bus.req_tag1 : bus.req_tag0;
`ifdef IMMARB_OPCHK_EN
      err_d    = ~opcode_legal(gen_inst[6:0]);
`endif
    end else if (load_en) begin
      // Drain: result consumed with nothing to replace it; payload holds.
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      rr_ptr_q <= 1'b0;
      imm_q    <= '0;
      id_q     <= 1'b0;
      tag_q    <= '0;
`ifdef IMMARB_OPCHK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      imm_q    <= imm_d;
      id_q     <= id_d;
      tag_q    <= tag_d;
`ifdef IMMARB_OPCHK_EN
      err_q    <= err_d;
`endif
    end
  end

  assign bus.req_ready  = grant;
  assign bus.gen_inst   = gen_inst;
  assign bus.out_valid  = (state_q == FULL);
  assign bus.out_imm    = imm_q;
  assign bus.out_id     = id_q;
  assign bus.out_tag    = tag_q;
  assign bus.dbg_state  = state_q;
  assign bus.dbg_rr_ptr = rr_ptr_q;
`ifdef IMMARB_OPCHK_EN
  assign bus.out_err    = err_q;
`endif

endmodule

// File: tb/tb_imm_gen_arbiter.sv
// Directed bench for imm_gen_arbiter. A behavioural RV64 immediate generator
// is attached to gen_inst/gen_imm; expected values are hand-computed constants.
module tb_imm_gen_arbiter;
  localparam int INST_W = 32;
  localparam int IMM_W  = 64;
  localparam int TAG_W  = 4;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  imm_gen_arbiter_if #(.INST_W(INST_W), .IMM_W(IMM_W), .TAG_W(TAG_W)) bus ();

  imm_gen_arbiter #(.INST_W(INST_W), .IMM_W(IMM_W), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock/reset block ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- shared imm_gen model ----------------
  function automatic logic [63:0] imm_of(input logic [31:0] i);
    case (i[6:0])
      7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111, 7'b1110011:
        imm_of = {{52{i[31]}}, i[31:20]};
      7'b0100011:
        imm_of = {{52{i[31]}}, i[31:25], i[11:7]};
      7'b1100011:
        imm_of = {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      7'b0110111, 7'b0010111:
        imm_of = {{32{i[31]}}, i[31:12], 12'b0};
      7'b1101111:
        imm_of = {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default:
        imm_of = 64'h0;
    endcase
  endfunction

  always_comb bus.gen_imm = imm_of(bus.gen_inst);

  // ---------------- driver/check tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic [1:0] v);
    bus.req_valid = v;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    bus.req_valid = 2'b11;
    bus.req_inst0 = 32'h0050_0093;
    bus.req_inst1 = 32'hFFF0_0093;
    bus.req_tag0  = 4'd3;
    bus.req_tag1  = 4'd9;
    bus.out_ready = 1'b1;

    // 1: reset with both requests pending
    tick();
    tick();
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_imm",   bus.out_imm, 64'd0);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_gen_inst",  64'(bus.gen_inst), 64'd0);
    rst_n = 1'b1;
    set_req(2'b00);
    tick();
    chk("post_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("post_rst_rr",    64'(bus.dbg_rr_ptr), 64'd0);

    // 2: single requester 0
    set_req(2'b01);
    #1;
    chk("s2_req_ready", 64'(bus.req_ready), 64'b01);
    chk("s2_gen_inst",  64'(bus.gen_inst), 64'h0050_0093);
    tick();
    chk("s2_valid", 64'(bus.out_valid), 64'd1);
    chk("s2_imm",   bus.out_imm, 64'h5);
    chk("s2_id",    64'(bus.out_id), 64'd0);
    chk("s2_tag",   64'(bus.out_tag), 64'd3);
    chk("s2_rr",    64'(bus.dbg_rr_ptr), 64'd1);
    bus.req_inst0 = 32'hFFF0_0093;
    bus.req_tag0  = 4'd5;
    tick();
    chk("s2_neg_imm", bus.out_imm, ONES);
    chk("s2_neg_tag", 64'(bus.out_tag), 64'd5);

    // drain: no request, payload holds
    set_req(2'b00);
    tick();
    chk("drain_valid", 64'(bus.out_valid), 64'd0);
    chk("drain_imm",   bus.out_imm, ONES);

    // single requester 1 moves rr_ptr to 0
    bus.req_inst1 = 32'h00A0_0113;
    bus.req_tag1  = 4'd7;
    set_req(2'b10);
    tick();
    chk("r1_imm", bus.out_imm, 64'hA);
    chk("r1_id",  64'(bus.out_id), 64'd1);
    chk("r1_tag", 64'(bus.out_tag), 64'd7);
    chk("r1_rr",  64'(bus.dbg_rr_ptr), 64'd0);

    // 3: both valid, back-to-back alternation 0,1,0,1
    bus.req_inst0 = 32'h0050_0093;
    bus.req_tag0  = 4'd3;
    bus.req_inst1 = 32'hFFF0_0093;
    bus.req_tag1  = 4'd9;
    set_req(2'b11);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("s3_req_ready", 64'(bus.req_ready), (k % 2 == 0) ? 64'b01 : 64'b10);
      tick();
      chk("s3_valid", 64'(bus.out_valid), 64'd1);
      chk("s3_id",    64'(bus.out_id), 64'(k % 2));
      chk("s3_imm",   bus.out_imm, (k % 2 == 0) ? 64'h5 : ONES);
    end

    // 4: back-pressure for 3 cycles
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("s4_req_ready", 64'(bus.req_ready), 64'b00);
      chk("s4_gen_inst",  64'(bus.gen_inst), 64'd0);
      tick();
      chk("s4_valid", 64'(bus.out_valid), 64'd1);
      chk("s4_id",    64'(bus.out_id), 64'd1);
      chk("s4_imm",   bus.out_imm, ONES);
      chk("s4_tag",   64'(bus.out_tag), 64'd9);
      chk("s4_rr",    64'(bus.dbg_rr_ptr), 64'd0);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("s4_release_ready", 64'(bus.req_ready), 64'b01);
    tick();
    chk("s4_new_valid", 64'(bus.out_valid), 64'd1);
    chk("s4_new_id",    64'(bus.out_id), 64'd0);
    chk("s4_new_imm",   bus.out_imm, 64'h5);
    chk("s4_new_tag",   64'(bus.out_tag), 64'd3);

    // 5: reset while FULL with requester 1 pending
    set_req(2'b10);
    rst_n = 1'b0;
    #1;
    chk("s5_req_ready", 64'(bus.req_ready), 64'b00);
    tick();
    chk("s5_valid", 64'(bus.out_valid), 64'd0);
    chk("s5_rr",    64'(bus.dbg_rr_ptr), 64'd0);
    chk("s5_imm",   bus.out_imm, 64'd0);
    rst_n = 1'b1;
    set_req(2'b00);
    tick();

`ifdef IMMARB_OPCHK_EN
    // 6: opcode check
    bus.req_inst0 = 32'h0020_81B3;
    set_req(2'b01);
    tick();
    chk("s6_err_rtype", 64'(bus.out_err), 64'd1);
    chk("s6_rtype_valid", 64'(bus.out_valid), 64'd1);
    bus.req_inst0 = 32'h0050_0093;
    tick();
    chk("s6_err_addi", 64'(bus.out_err), 64'd0);
    set_req(2'b00);
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety bound so the run always terminates.
  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
